dense_seq: RTL

Sequential, parametrised dense (fully-connected) layer for the hand-sign inference chain. It replaces the all-at-once combinational matrix multiply with a single-MAC datapath that streams weights from an external synchronous ROM. It accepts an input vector over a valid/ready stream and emits output neurons one at a time over a second valid/ready stream. Optional ReLU, output saturation and argmax (final-layer letter index) are selected by parameter.

---
 rtl/dense_seq_if.sv | 35 +++
 rtl/dense_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dense_seq_if.sv
// Stream, weight-ROM and result signals of dense_seq; slave is the layer, master is its environment.
// Data-carrying fields are signed so sign extension survives module boundaries.
interface dense_seq_if #(
  parameter int IBW   = 15,
  parameter int KBW   = 15,
  parameter int AW    = 16,
  parameter int IXW   = 9,
  parameter int OUT_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IBW:0]     in_data;
  logic                    w_rd_en;
  logic [AW-1:0]           w_addr;
  logic signed [KBW:0]     w_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;
  logic                    argmax_valid;
  logic [IXW-1:0]          argmax_index;
  logic                    busy;

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data, out_last,
           argmax_valid, argmax_index, busy
  );

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_last,
           argmax_valid, argmax_index, busy
  );
endinterface

// File: rtl/dense_seq.sv
// Single-MAC dense layer: buffers one input vector, then emits OUT_LEN neurons, each IN_LEN+2 cycles.
// Output holds in EMIT while out_ready is low; no weight reads are issued during the stall.
module dense_seq #(
  parameter int IBW       = 15,
  parameter int KBW       = 15,
  parameter int IN_LEN    = 128,
  parameter int OUT_LEN   = 512,
  parameter int ACC_W     = IBW + KBW + 2 + $clog2(IN_LEN),
  parameter int OUT_W     = 32,
  parameter int RELU_EN   = 1,
  parameter int ARGMAX_EN = 0,
  parameter int AW        = $clog2(IN_LEN * OUT_LEN),
  parameter int IXW       = $clog2(OUT_LEN)
) (
  input  logic        clk,
  input  logic        rst,
  dense_seq_if.slave  bus
);
  localparam int KW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int PW = IBW + KBW + 2;
  localparam int SW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_COMP  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [KW-1:0]           ld_cnt_q, ld_cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [KW-1:0]           rd_k_q, rd_k_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [IXW-1:0]          j_q, j_d;
  logic [IXW-1:0]          best_idx_q, best_idx_d;
  logic [IXW-1:0]          argmax_index_q, argmax_index_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] max_q, max_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic signed [IBW:0]     in_buf_q [IN_LEN];
  logic signed [IBW:0]     in_buf_d [IN_LEN];

  logic                    in_fire;
  logic                    out_fire;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [SW-1:0]    sat_in;
  logic signed [OUT_W-1:0] sat_out;

  assign in_fire  = (state_q == S_LOAD) && bus.in_valid;
  assign out_fire = (state_q == S_EMIT) && bus.out_ready;

  // w_data answers the read issued last cycle, so the product uses that read's k.
  assign prod    = $signed(in_buf_q[rd_k_q]) * $signed(bus.w_data);
  assign acc_sum = rd_vld_q ? (acc_q + ACC_W'(prod)) : acc_q;

  always_comb begin
    sat_in = SW'(acc_sum);
    if ((RELU_EN != 0) && acc_sum[ACC_W-1]) begin
      sat_in = '0;
    end
    if (sat_in > SAT_MAX) begin
      sat_out = SAT_MAX[OUT_W-1:0];
    end else if (sat_in < SAT_MIN) begin
      sat_out = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_out = sat_in[OUT_W-1:0];
    end
  end

  always_comb begin
    in_buf_d = in_buf_q;
    if (in_fire) begin
      in_buf_d[ld_cnt_q] = bus.in_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    ld_cnt_d       = ld_cnt_q;
    k_d            = k_q;
    rd_k_d         = k_q;
    rd_vld_d       = 1'b0;
    j_d            = j_q;
    best_idx_d     = best_idx_q;
    argmax_index_d = argmax_index_q;
    acc_d          = acc_q;
    max_d          = max_q;
    out_data_d     = out_data_q;

    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          ld_cnt_d = ld_cnt_q + KW'(1);
          if (ld_cnt_q == KW'(IN_LEN - 1)) begin
            state_d    = S_COMP;
            ld_cnt_d   = '0;
            j_d        = '0;
            k_d        = '0;
            acc_d      = '0;
            max_d      = '0;
            best_idx_d = '0;
          end
        end
      end
      S_COMP: begin
        rd_vld_d = 1'b1;
        acc_d    = acc_sum;
        if (k_q == KW'(IN_LEN - 1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        acc_d      = acc_sum;
        out_data_d = sat_out;
        state_d    = S_EMIT;
      end
      S_EMIT: begin
        if (out_fire) begin
          // Strict compare keeps the lowest index on ties.
          if ((ARGMAX_EN != 0) && (out_data_q > max_q)) begin
            max_d      = out_data_q;
            best_idx_d = j_q;
          end
          if (j_q == IXW'(OUT_LEN - 1)) begin
            state_d        = S_FIN;
            argmax_index_d = best_idx_d;
          end else begin
            state_d = S_COMP;
            j_d     = j_q + IXW'(1);
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      S_FIN: begin
        state_d  = S_LOAD;
        ld_cnt_d = '0;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_LOAD;
      ld_cnt_q       <= '0;
      k_q            <= '0;
      rd_k_q         <= '0;
      rd_vld_q       <= 1'b0;
      j_q            <= '0;
      best_idx_q     <= '0;
      argmax_index_q <= '0;
      acc_q          <= '0;
      max_q          <= '0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      k_q            <= k_d;
      rd_k_q         <= rd_k_d;
      rd_vld_q       <= rd_vld_d;
      j_q            <= j_d;
      best_idx_q     <= best_idx_d;
      argmax_index_q <= argmax_index_d;
      acc_q          <= acc_d;
      max_q          <= max_d;
      out_data_q     <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    in_buf_q <= in_buf_d;
  end

  assign bus.in_ready     = (state_q == S_LOAD);
  assign bus.w_rd_en      = (state_q == S_COMP);
  assign bus.w_addr       = (state_q == S_COMP) ? (AW'(k_q) * AW'(OUT_LEN) + AW'(j_q)) : '0;
  assign bus.out_valid    = (state_q == S_EMIT);
  assign bus.out_last     = (state_q == S_EMIT) && (j_q == IXW'(OUT_LEN - 1));
  assign bus.out_data     = out_data_q;
  assign bus.argmax_valid = (ARGMAX_EN != 0) && (state_q == S_FIN);
  assign bus.argmax_index = argmax_index_q;
  assign bus.busy         = (state_q != S_LOAD);
endmodule
